// File: rtl/ddr4_v2_2_20_axi_rw_cmd_sched_if.sv
// Command bus bundle for the AW/AR scheduler: the AW and AR request sides plus
// the single shared downstream command port.
interface ddr4_v2_2_20_axi_rw_cmd_sched_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_ID_WIDTH   = 4,
  parameter int C_LEN_WIDTH  = 8
);
  logic                    S_AW_VALID;
  logic                    S_AW_READY;
  logic [C_ADDR_WIDTH-1:0] S_AW_ADDR;
  logic [C_ID_WIDTH-1:0]   S_AW_ID;
  logic [C_LEN_WIDTH-1:0]  S_AW_LEN;
  logic                    S_AR_VALID;
  logic                    S_AR_READY;
  logic [C_ADDR_WIDTH-1:0] S_AR_ADDR;
  logic [C_ID_WIDTH-1:0]   S_AR_ID;
  logic [C_LEN_WIDTH-1:0]  S_AR_LEN;
  logic                    M_CMD_VALID;
  logic                    M_CMD_READY;
  logic                    M_CMD_WRITE;
  logic [C_ADDR_WIDTH-1:0] M_CMD_ADDR;
  logic [C_ID_WIDTH-1:0]   M_CMD_ID;
  logic [C_LEN_WIDTH-1:0]  M_CMD_LEN;

  // Scheduler view: receives AW/AR requests, drives the shared command port.
  modport slave (
    input  S_AW_VALID, S_AW_ADDR, S_AW_ID, S_AW_LEN,
    input  S_AR_VALID, S_AR_ADDR, S_AR_ID, S_AR_LEN,
    input  M_CMD_READY,
    output S_AW_READY, S_AR_READY,
    output M_CMD_VALID, M_CMD_WRITE, M_CMD_ADDR, M_CMD_ID, M_CMD_LEN
  );

  // Environment view: upstream request sources and downstream command sink.
  modport master (
    output S_AW_VALID, S_AW_ADDR, S_AW_ID, S_AW_LEN,
    output S_AR_VALID, S_AR_ADDR, S_AR_ID, S_AR_LEN,
    output M_CMD_READY,
    input  S_AW_READY, S_AR_READY,
    input  M_CMD_VALID, M_CMD_WRITE, M_CMD_ADDR, M_CMD_ID, M_CMD_LEN
  );
endinterface

// File: rtl/ddr4_v2_2_20_axi_rw_cmd_sched.sv
// AW/AR command scheduler: keeps issuing in the current direction to limit bus
// turnarounds, bounded by C_MAX_RUN under contention; one registered output stage.
module ddr4_v2_2_20_axi_rw_cmd_sched #(
  parameter string C_FAMILY     = "virtex6",
  parameter int    C_ADDR_WIDTH = 32,
  parameter int    C_ID_WIDTH   = 4,
  parameter int    C_LEN_WIDTH  = 8,
  parameter int    C_MAX_RUN    = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
  ddr4_v2_2_20_axi_rw_cmd_sched_if.slave bus
);

  if ((C_MAX_RUN < 1) || (C_MAX_RUN > 15)) begin : g_bad_max_run
    $error("%s: C_MAX_RUN must be within 1..15", C_FAMILY);
  end

  typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_e;

  localparam logic [3:0] RUN_LIM = 4'(C_MAX_RUN);

  dir_e                    last_dir;
  dir_e                    win_dir;
  logic [3:0]              run_cnt;
  logic                    win_vld;
  logic                    load_ok;
  logic                    s_hs;
  logic [C_ADDR_WIDTH-1:0] nxt_addr;
  logic [C_ID_WIDTH-1:0]   nxt_id;
  logic [C_LEN_WIDTH-1:0]  nxt_len;

  logic                    m_valid;
  logic                    m_write;
  logic [C_ADDR_WIDTH-1:0] m_addr;
  logic [C_ID_WIDTH-1:0]   m_id;
  logic [C_LEN_WIDTH-1:0]  m_len;

  // Arbitration looks only at VALIDs and the run state, never at payload.
  always_comb begin
    win_vld = bus.S_AW_VALID | bus.S_AR_VALID;
    win_dir = DIR_RD;
    if (bus.S_AW_VALID && bus.S_AR_VALID) begin
      if (run_cnt < RUN_LIM) win_dir = last_dir;
      else                   win_dir = (last_dir == DIR_WR) ? DIR_RD : DIR_WR;
    end else if (bus.S_AW_VALID) begin
      win_dir = DIR_WR;
    end
  end

  always_comb begin
    nxt_addr = bus.S_AR_ADDR;
    nxt_id   = bus.S_AR_ID;
    nxt_len  = bus.S_AR_LEN;
    if (win_dir == DIR_WR) begin
      nxt_addr = bus.S_AW_ADDR;
      nxt_id   = bus.S_AW_ID;
      nxt_len  = bus.S_AW_LEN;
    end
  end

  assign load_ok        = !m_valid | bus.M_CMD_READY;
  assign s_hs           = ARESETN & load_ok & win_vld;
  assign bus.S_AW_READY = s_hs & (win_dir == DIR_WR);
  assign bus.S_AR_READY = s_hs & (win_dir == DIR_RD);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_valid  <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_id     <= '0;
      m_len    <= '0;
      last_dir <= DIR_RD;
      run_cnt  <= '0;
    end else if (s_hs) begin
      m_valid <= 1'b1;
      m_write <= (win_dir == DIR_WR);
      m_addr  <= nxt_addr;
      m_id    <= nxt_id;
      m_len   <= nxt_len;
      if (win_dir == last_dir) begin
        if (run_cnt != 4'hF) run_cnt <= run_cnt + 4'd1;
      end else begin
        run_cnt  <= 4'd1;
        last_dir <= win_dir;
      end
    end else if (bus.M_CMD_READY) begin
      m_valid <= 1'b0;
    end
  end

  assign bus.M_CMD_VALID = m_valid;
  assign bus.M_CMD_WRITE = m_write;
  assign bus.M_CMD_ADDR  = m_addr;
  assign bus.M_CMD_ID    = m_id;
  assign bus.M_CMD_LEN   = m_len;

endmodule

// File: doc/ddr4_v2_2_20_axi_rw_cmd_sched.md
Name: ddr4_v2_2_20_axi_rw_cmd_sched

Overview:
- Schedules AXI write-address (AW) and read-address (AR) commands from the upsizer front end onto the single shared command port of the memory-controller adapter.
- Favours continuing in the current direction to reduce DRAM bus turnarounds.
- Bounds a run in one direction with a programmable limit, so the opposite side is never starved.
- Has a one-entry registered output stage and sustains one command per cycle.

Parameters:
- C_FAMILY, "virtex6", FPGA family; informational only, no effect on behaviour.
- C_ADDR_WIDTH, 32, command address width.
- C_ID_WIDTH, 4, AXI ID width.
- C_LEN_WIDTH, 8, AXI burst-length field width.
- C_MAX_RUN, 4, maximum consecutive same-direction grants while the other side is pending; legal range 1..15.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AW_VALID  in  1  write command valid.
- S_AW_READY  out  1  write command accepted.
- S_AW_ADDR  in  C_ADDR_WIDTH  write address.
- S_AW_ID  in  C_ID_WIDTH  write ID.
- S_AW_LEN  in  C_LEN_WIDTH  write burst length.
- S_AR_VALID  in  1  read command valid.
- S_AR_READY  out  1  read command accepted.
- S_AR_ADDR  in  C_ADDR_WIDTH  read address.
- S_AR_ID  in  C_ID_WIDTH  read ID.
- S_AR_LEN  in  C_LEN_WIDTH  read burst length.
- M_CMD_VALID  out  1  scheduled command valid.
- M_CMD_READY  in  1  downstream accepts.
- M_CMD_WRITE  out  1  1 = write, 0 = read.
- M_CMD_ADDR  out  C_ADDR_WIDTH  address.
- M_CMD_ID  out  C_ID_WIDTH  ID.
- M_CMD_LEN  out  C_LEN_WIDTH  length.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - M_CMD_VALID=0; M_CMD_WRITE/ADDR/ID/LEN=0.
  - last_dir=read; run_cnt=0.
  - S_AW_READY=S_AR_READY=0 while reset is asserted.
  - Deassertion is sampled synchronously to ACLK.
- Load enable: load_ok = !M_CMD_VALID | M_CMD_READY.
- Arbitration (combinational, evaluated every cycle):
  - Only one side valid: that side wins.
  - Both valid, run_cnt < C_MAX_RUN: winner = last_dir.
  - Both valid, run_cnt >= C_MAX_RUN: winner = !last_dir.
  - Neither valid: no winner.
- Ready outputs:
  - S_AW_READY = load_ok & (winner==write).
  - S_AR_READY = load_ok & (winner==read).
  - Never both high in the same cycle.
  - Ready may depend combinationally on VALID, the other side's VALID and M_CMD_READY; there is no combinational path from any S_*_ADDR/ID/LEN to a READY.
- On an S-side handshake:
  - Output register loads the winner's fields and M_CMD_WRITE.
  - M_CMD_VALID=1 next cycle; latency 1 cycle.
- run_cnt on an S-side handshake:
  - If winner==last_dir: run_cnt = min(run_cnt+1, 15); saturates, no wrap.
  - Else: run_cnt=1 and last_dir=winner.
- M-side handshake with no S-side handshake in the same cycle: M_CMD_VALID=0 next cycle.
- Simultaneous M-side and S-side handshakes: the register reloads; M_CMD_VALID stays 1. Back-to-back throughput is 1 command/cycle.
- M_CMD_READY low while M_CMD_VALID=1:
  - All M_CMD_* held stable (AXI stability rule).
  - Both S_*_READY = 0.
  - run_cnt and last_dir unchanged.
- Run-counter behaviour with the other side idle:
  - A lone valid side keeps winning with no limit.
  - run_cnt keeps counting, so the other side is served on its first cycle of contention once the limit is reached.
- C_MAX_RUN=1: strict alternation under contention.
- Reset mid-operation: any in-flight M_CMD is dropped (VALID=0). Upstream re-presents commands per AXI; this is acceptable because the whole AXI path resets together.
- No FIFO: the only storage is the single output register plus last_dir and a 4-bit run_cnt.

Test Plan:
- Reset values: hold ARESETN low with S_AW_VALID=S_AR_VALID=1 -> both READY=0, M_CMD_VALID=0, all M_CMD_* =0; release -> first grant is AR (last_dir=read, run_cnt=0<4), M_CMD_WRITE=0 one cycle later.
- Single stream: AW only, 6 commands, ADDR=0x100+0x40*n, M_CMD_READY=1 -> 6 consecutive cycles of M_CMD_VALID=1, WRITE=1, addresses in order, latency 1.
- Run limit: after 3 writes, both sides valid continuously, C_MAX_RUN=4 -> exactly 1 more write (4 total), then 4 reads, then writes; pattern W W W W R R R R W...
- Backpressure: M_CMD_READY=0 for 5 cycles with ADDR=0xABC0 loaded -> M_CMD_* stable, both S_*_READY=0, run_cnt unchanged; READY=1 -> next command follows the next cycle with no bubble.
- Strict alternation: C_MAX_RUN=1, both valid for 6 commands -> R W R W R W with IDs matching sources.
- Reset mid-burst: assert ARESETN low while M_CMD_VALID=1, M_CMD_READY=0 -> M_CMD_VALID drops to 0 immediately (asynchronously, no clock edge), run_cnt=0, last_dir=read after release.
